// File: rtl/y86_pkg.sv
// Y86-64 constants shared by fetch, decode, execute and write-back:
// status codes, register ids and instruction codes.
package y86_pkg;

    localparam logic [3:0] STAT_AOK = 4'h1;
    localparam logic [3:0] STAT_HLT = 4'h2;
    localparam logic [3:0] STAT_ADR = 4'h3;
    localparam logic [3:0] STAT_INS = 4'h4;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Status latched when a non-AOK instruction retires; undefined codes count as INS.
    function automatic logic [3:0] fault_stat(input logic [3:0] s);
        if (s == STAT_HLT || s == STAT_ADR || s == STAT_INS)
            return s;
        return STAT_INS;
    endfunction

endpackage

// File: rtl/regfile_2w.sv
// Register array with two write ports (E and M) sharing one enable.
// When both ports target the same register, port M wins (popq %rsp).
module regfile_2w
    import y86_pkg::*;
#(
    parameter int NREGS = 15,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [3:0]             dst_e,
    input  logic [WIDTH-1:0]       val_e,
    input  logic [3:0]             dst_m,
    input  logic [WIDTH-1:0]       val_m,
    output logic [NREGS*WIDTH-1:0] values
);

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            localparam logic [3:0] IDX = 4'(gi);
            logic [WIDTH-1:0] data_reg;

            // RNONE never matches since indices stop at NREGS-1.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    data_reg <= '0;
                else if (we && dst_m == IDX)
                    data_reg <= val_m;
                else if (we && dst_e == IDX)
                    data_reg <= val_e;
            end

            assign values[gi*WIDTH +: WIDTH] = data_reg;
        end
    endgenerate

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage: commits W results to the register file, tracks processor
// status and stops all commits once a non-AOK instruction retires.
module writeback_regfile
    import y86_pkg::*;
#(
    parameter int NREGS = 15,
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       W_stat,
    input  logic [3:0]       W_icode,
    input  logic [3:0]       W_dstE,
    input  logic [WIDTH-1:0] W_valE,
    input  logic [3:0]       W_dstM,
    input  logic [WIDTH-1:0] W_valM,
    output logic [WIDTH-1:0] value0,
    output logic [WIDTH-1:0] value1,
    output logic [WIDTH-1:0] value2,
    output logic [WIDTH-1:0] value3,
    output logic [WIDTH-1:0] value4,
    output logic [WIDTH-1:0] value5,
    output logic [WIDTH-1:0] value6,
    output logic [WIDTH-1:0] value7,
    output logic [WIDTH-1:0] value8,
    output logic [WIDTH-1:0] value9,
    output logic [WIDTH-1:0] value10,
    output logic [WIDTH-1:0] value11,
    output logic [WIDTH-1:0] value12,
    output logic [WIDTH-1:0] value13,
    output logic [WIDTH-1:0] value14,
    output logic [3:0]       Stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_STOPPED = 1'b1;

    logic [0:0]             state_reg;
    logic [3:0]             stat_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   commit;
    logic [NREGS*WIDTH-1:0] values;

    assign commit = (state_reg == ST_RUN) && (W_stat == STAT_AOK);

    regfile_2w #(
        .NREGS(NREGS),
        .WIDTH(WIDTH)
    ) u_regs (
        .clk   (clk),
        .rst   (rst),
        .we    (commit),
        .dst_e (W_dstE),
        .val_e (W_valE),
        .dst_m (W_dstM),
        .val_m (W_valM),
        .values(values)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RUN;
            stat_reg  <= STAT_AOK;
            cnt_reg   <= '0;
        end else if (state_reg == ST_RUN) begin
            if (W_stat == STAT_AOK) begin
                // Bubbles are not real instructions; counter sticks at all-ones.
                if (W_icode != INOP && cnt_reg != '1)
                    cnt_reg <= cnt_reg + CNT_W'(1);
            end else begin
                stat_reg  <= fault_stat(W_stat);
                state_reg <= ST_STOPPED;
            end
        end
    end

    assign Stat        = stat_reg;
    assign halted      = (state_reg == ST_STOPPED);
    assign retired_cnt = cnt_reg;

    assign value0  = values[0*WIDTH  +: WIDTH];
    assign value1  = values[1*WIDTH  +: WIDTH];
    assign value2  = values[2*WIDTH  +: WIDTH];
    assign value3  = values[3*WIDTH  +: WIDTH];
    assign value4  = values[4*WIDTH  +: WIDTH];
    assign value5  = values[5*WIDTH  +: WIDTH];
    assign value6  = values[6*WIDTH  +: WIDTH];
    assign value7  = values[7*WIDTH  +: WIDTH];
    assign value8  = values[8*WIDTH  +: WIDTH];
    assign value9  = values[9*WIDTH  +: WIDTH];
    assign value10 = values[10*WIDTH +: WIDTH];
    assign value11 = values[11*WIDTH +: WIDTH];
    assign value12 = values[12*WIDTH +: WIDTH];
    assign value13 = values[13*WIDTH +: WIDTH];
    assign value14 = values[14*WIDTH +: WIDTH];

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: a 32-bit-counter instance and a 4-bit
// counter instance share the same W-stage inputs.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  W_stat, W_icode, W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;

    logic [63:0] vals [15];
    logic [3:0]  stat_a;
    logic        halted_a;
    logic [31:0] cnt_a;

    logic [63:0] vals4 [15];
    logic [3:0]  stat_b;
    logic        halted_b;
    logic [3:0]  cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    writeback_regfile #(.NREGS(15), .WIDTH(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .W_stat(W_stat), .W_icode(W_icode),
        .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .value0(vals[0]), .value1(vals[1]), .value2(vals[2]), .value3(vals[3]),
        .value4(vals[4]), .value5(vals[5]), .value6(vals[6]), .value7(vals[7]),
        .value8(vals[8]), .value9(vals[9]), .value10(vals[10]), .value11(vals[11]),
        .value12(vals[12]), .value13(vals[13]), .value14(vals[14]),
        .Stat(stat_a), .halted(halted_a), .retired_cnt(cnt_a)
    );

    writeback_regfile #(.NREGS(15), .WIDTH(64), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .W_stat(W_stat), .W_icode(W_icode),
        .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .value0(vals4[0]), .value1(vals4[1]), .value2(vals4[2]), .value3(vals4[3]),
        .value4(vals4[4]), .value5(vals4[5]), .value6(vals4[6]), .value7(vals4[7]),
        .value8(vals4[8]), .value9(vals4[9]), .value10(vals4[10]), .value11(vals4[11]),
        .value12(vals4[12]), .value13(vals4[13]), .value14(vals4[14]),
        .Stat(stat_b), .halted(halted_b), .retired_cnt(cnt_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one W-stage transaction, clock it in, settle 1 time unit past the edge.
    task automatic step(input logic [3:0] stat, input logic [3:0] icode,
                        input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm);
        W_stat = stat; W_icode = icode;
        W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
        @(posedge clk);
        #1;
        $display("t=%0t stat=%0h icode=%0h dstE=%0h valE=%0h dstM=%0h valM=%0h -> Stat=%0h halted=%0b cnt=%0d",
                 $time, stat, icode, de, ve, dm, vm, stat_a, halted_a, cnt_a);
    endtask

    task automatic chk_all_zero(input string tag);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 15; i++)
            if (vals[i] !== 64'h0 || vals4[i] !== 64'h0) ok = 1'b0;
        chk(tag, {63'h0, ok}, 64'h1);
    endtask

    initial begin
        rst = 1'b1;
        W_stat = 4'h1; W_icode = 4'h1; W_dstE = 4'hF; W_dstM = 4'hF;
        W_valE = '0; W_valM = '0;
        @(posedge clk); #1;
        chk_all_zero("reset_regs");
        chk("reset_stat", 64'(stat_a), 64'h1);
        chk("reset_halted", 64'(halted_a), 64'h0);
        chk("reset_cnt", 64'(cnt_a), 64'h0);
        rst = 1'b0;

        // Dual write through both ports on one edge.
        step(4'h1, 4'h6, 4'h3, 64'h1234, 4'h7, 64'hABCD);
        chk("dual_value3", vals[3], 64'h1234);
        chk("dual_value7", vals[7], 64'hABCD);
        chk("dual_cnt", 64'(cnt_a), 64'h1);

        // Same destination on both ports: M wins.
        step(4'h1, 4'hB, 4'h4, 64'h100, 4'h4, 64'h200);
        chk("collide_value4", vals[4], 64'h200);
        chk("collide_cnt", 64'(cnt_a), 64'h2);

        // Bubble with no destinations.
        step(4'h1, 4'h1, 4'hF, 64'hDEAD, 4'hF, 64'hBEEF);
        chk("bubble_value3", vals[3], 64'h1234);
        chk("bubble_value4", vals[4], 64'h200);
        chk("bubble_value7", vals[7], 64'hABCD);
        chk("bubble_cnt", 64'(cnt_a), 64'h2);

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst_regs");
        chk("async_rst_stat", 64'(stat_a), 64'h1);
        chk("async_rst_halted", 64'(halted_a), 64'h0);
        chk("async_rst_cnt", 64'(cnt_a), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 17 non-bubble retires: 4-bit counter saturates at 15.
        for (int i = 0; i < 17; i++)
            step(4'h1, 4'h6, 4'hF, 64'h0, 4'hF, 64'h0);
        chk("sat_cnt4", 64'(cnt_b), 64'hF);
        chk("sat_cnt32", 64'(cnt_a), 64'd17);

        step(4'h1, 4'h3, 4'h2, 64'h11, 4'hF, 64'h0);
        chk("pre_halt_value2", vals[2], 64'h11);
        chk("pre_halt_cnt", 64'(cnt_a), 64'd18);
        chk("pre_halt_halted", 64'(halted_a), 64'h0);

        // HLT retires: no write, status latched.
        step(4'h2, 4'h0, 4'h2, 64'h55, 4'hF, 64'h0);
        chk("halt_value2", vals[2], 64'h11);
        chk("halt_stat", 64'(stat_a), 64'h2);
        chk("halt_halted", 64'(halted_a), 64'h1);
        chk("halt_cnt", 64'(cnt_a), 64'd18);

        // Stopped: AOK input still suppressed.
        step(4'h1, 4'h3, 4'h2, 64'h66, 4'h9, 64'h77);
        chk("stopped_value2", vals[2], 64'h11);
        chk("stopped_value9", vals[9], 64'h0);
        chk("stopped_stat", 64'(stat_a), 64'h2);
        chk("stopped_cnt", 64'(cnt_a), 64'd18);

        // Out-of-range status is recorded as INS.
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        step(4'h9, 4'h6, 4'h5, 64'h99, 4'hF, 64'h0);
        chk("badstat_stat", 64'(stat_a), 64'h4);
        chk("badstat_halted", 64'(halted_a), 64'h1);
        chk("badstat_stat4", 64'(stat_b), 64'h4);
        chk("badstat_halted4", 64'(halted_b), 64'h1);
        chk("badstat_value5", vals[5], 64'h0);
        chk("badstat_cnt", 64'(cnt_a), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
